// File: rtl/step_scheduler_pkg.sv
// Shared types and sizing for the step scheduler: mode and state encodings, voice masks,
// and the step-index to one-hot helper.
package step_scheduler_pkg;

  localparam int unsigned STEPS  = 8;
  localparam int unsigned VOICES = 4;
  localparam int unsigned CNT_W  = 20;
  localparam int unsigned IDX_W  = $clog2(STEPS);

  typedef enum logic [1:0] {
    MODE_EDIT = 2'd0,
    MODE_PLAY = 2'd1,
    MODE_RAW  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [VOICES-1:0] voice_mask_t;
  typedef logic [IDX_W-1:0]  step_idx_t;

  function automatic logic [STEPS-1:0] idx_onehot(input step_idx_t idx);
    logic [STEPS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/step_scheduler_timer.sv
// Step-length counter: counts up each clock, reports the terminal cycle (cnt >= lim) and
// wraps to zero there; a synchronous clear holds it at zero.
module step_scheduler_timer
  import step_scheduler_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] lim_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // >= rather than == so a step_len shortened below the running count still ends the step.
  assign term_o = !clr_i && (cnt_q >= lim_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || term_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Play-mode step sequencer: 8x4 pattern store, tempo-driven step pointer, gated voice enables.
// Optional STEP_SCHED_RETRIG_EN: voices reused across a step boundary drop for one clock.
module step_scheduler
  import step_scheduler_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  mode_t                   mode_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_step_i,
  input  logic [VOICES-1:0]       wr_mask_i,
  input  logic [VOICES-1:0]       raw_mask_i,
  input  logic [CNT_W-1:0]        step_len_i,
  input  logic [CNT_W-1:0]        gate_len_i,
  output logic [VOICES-1:0]       play_smpl_o,
  output logic [IDX_W-1:0]        step_idx_o,
  output logic [STEPS-1:0]        step_onehot_o,
  output logic                    beat_pulse_o,
  output logic [STEPS*VOICES-1:0] pattern_o
);

  state_t                       state_q, state_d;
  step_idx_t                    step_idx_q, step_idx_d, nxt_idx_s;
  voice_mask_t                  cur_mask_q, cur_mask_d;
  voice_mask_t                  play_smpl_q, play_smpl_d, voice_en_s;
  logic [STEPS-1:0][VOICES-1:0] pattern_q, pattern_d;
  logic [STEPS-1:0]             onehot_q, onehot_d;
  logic                         beat_q, beat_d;
  logic [CNT_W-1:0]             cnt_s;
  logic                         term_s;
  logic                         clr_s;
`ifdef STEP_SCHED_RETRIG_EN
  voice_mask_t                  retrig_q, retrig_d;
`endif

  // The counter only runs while playing; any other cycle holds it (and re-entry) at zero.
  assign clr_s     = !((state_q == ST_RUN) && (mode_i == MODE_PLAY));
  assign nxt_idx_s = step_idx_q + IDX_W'(1);

  step_scheduler_timer u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_s),
    .lim_i  (step_len_i),
    .cnt_o  (cnt_s),
    .term_o (term_s)
  );

  always_comb begin
    state_d    = state_q;
    step_idx_d = step_idx_q;
    cur_mask_d = cur_mask_q;
    beat_d     = 1'b0;
`ifdef STEP_SCHED_RETRIG_EN
    retrig_d   = retrig_q;
`endif
    case (state_q)
      ST_IDLE: begin
        step_idx_d = '0;
        if (mode_i == MODE_PLAY) begin
          state_d    = ST_RUN;
          cur_mask_d = pattern_q[0];
          beat_d     = 1'b1;
`ifdef STEP_SCHED_RETRIG_EN
          retrig_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mode_i != MODE_PLAY) begin
          state_d    = ST_IDLE;
          step_idx_d = '0;
        end else if (term_s) begin
          step_idx_d = nxt_idx_s;
          cur_mask_d = pattern_q[nxt_idx_s];
          beat_d     = 1'b1;
`ifdef STEP_SCHED_RETRIG_EN
          retrig_d   = cur_mask_q & pattern_q[nxt_idx_s];
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        step_idx_d = '0;
      end
    endcase
  end

  // Edits land in the register array only; a step load on the same clock reads the old value.
  always_comb begin
    pattern_d = pattern_q;
    if (wr_en_i) begin
      pattern_d[wr_step_i] = pattern_q[wr_step_i] ^ wr_mask_i;
    end else begin
      pattern_d = pattern_q;
    end
  end

  always_comb begin
    voice_en_s = '0;
    if ((state_q == ST_RUN) && (cnt_s < gate_len_i)) begin
      voice_en_s = cur_mask_q;
    end else begin
      voice_en_s = '0;
    end
`ifdef STEP_SCHED_RETRIG_EN
    if ((state_q == ST_RUN) && (cnt_s == '0)) begin
      voice_en_s = voice_en_s & ~retrig_q;
    end else begin
      voice_en_s = voice_en_s;
    end
`endif
    case (mode_i)
      MODE_PLAY: play_smpl_d = voice_en_s | raw_mask_i;
      MODE_RAW:  play_smpl_d = raw_mask_i;
      default:   play_smpl_d = '0;
    endcase
    if (state_d == ST_RUN) begin
      onehot_d = idx_onehot(step_idx_d);
    end else begin
      onehot_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      step_idx_q  <= '0;
      cur_mask_q  <= '0;
      play_smpl_q <= '0;
      pattern_q   <= '0;
      onehot_q    <= '0;
      beat_q      <= 1'b0;
`ifdef STEP_SCHED_RETRIG_EN
      retrig_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      step_idx_q  <= step_idx_d;
      cur_mask_q  <= cur_mask_d;
      play_smpl_q <= play_smpl_d;
      pattern_q   <= pattern_d;
      onehot_q    <= onehot_d;
      beat_q      <= beat_d;
`ifdef STEP_SCHED_RETRIG_EN
      retrig_q    <= retrig_d;
`endif
    end
  end

  assign play_smpl_o   = play_smpl_q;
  assign step_idx_o    = step_idx_q;
  assign step_onehot_o = onehot_q;
  assign beat_pulse_o  = beat_q;
  assign pattern_o     = pattern_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: a step-counting reference model compared every cycle, plus
// directed literal checks of tempo, gating, edit timing, RAW hand-off and retrigger.
module tb_step_scheduler;
  import step_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  mode_t       mode;
  logic        wr_en;
  logic [2:0]  wr_step;
  logic [3:0]  wr_mask, raw_mask;
  logic [19:0] step_len, gate_len;
  logic [3:0]  play;
  logic [2:0]  idx;
  logic [7:0]  oh;
  logic        beat;
  logic [31:0] pat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  step_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mode_i       (mode),
    .wr_en_i      (wr_en),
    .wr_step_i    (wr_step),
    .wr_mask_i    (wr_mask),
    .raw_mask_i   (raw_mask),
    .step_len_i   (step_len),
    .gate_len_i   (gate_len),
    .play_smpl_o  (play),
    .step_idx_o   (idx),
    .step_onehot_o(oh),
    .beat_pulse_o (beat),
    .pattern_o    (pat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute step count and position inside the current step.
  bit         m_valid = 1'b0;
  bit         m_run;
  int         m_pos, m_step;
  logic [3:0] m_mask, m_retrig;
  logic [3:0] m_pat [8];
  logic [3:0] e_play;
  logic       e_beat;
  logic [2:0] e_idx;
  logic [7:0] e_oh;

  function automatic void model_step();
    logic [3:0] ven;
    logic [3:0] nm;
    if (!rst_n) begin
      m_run = 1'b0; m_pos = 0; m_step = 0; m_mask = 4'b0; m_retrig = 4'b0;
      foreach (m_pat[i]) m_pat[i] = 4'b0;
      e_play = 4'b0; e_beat = 1'b0; e_idx = 3'd0; e_oh = 8'b0;
      return;
    end
    ven = (m_run && (m_pos < int'(gate_len))) ? m_mask : 4'b0;
`ifdef STEP_SCHED_RETRIG_EN
    if (m_run && m_pos == 0) ven = ven & ~m_retrig;
`endif
    case (mode)
      MODE_PLAY: e_play = ven | raw_mask;
      MODE_RAW:  e_play = raw_mask;
      default:   e_play = 4'b0;
    endcase
    e_beat = 1'b0;
    if (!m_run) begin
      if (mode == MODE_PLAY) begin
        m_run = 1'b1; m_pos = 0; m_step = 0; m_mask = m_pat[0]; m_retrig = 4'b0; e_beat = 1'b1;
      end
    end else if (mode != MODE_PLAY) begin
      m_run = 1'b0; m_pos = 0; m_step = 0;
    end else if (m_pos >= int'(step_len)) begin
      m_pos = 0;
      m_step++;
      nm = m_pat[m_step % 8];
      m_retrig = m_mask & nm;
      m_mask = nm;
      e_beat = 1'b1;
    end else begin
      m_pos++;
    end
    if (wr_en) m_pat[wr_step] = m_pat[wr_step] ^ wr_mask;
    e_idx = 3'(m_step % 8);
    e_oh  = m_run ? (8'b1 << e_idx) : 8'b0;
  endfunction

  // Compare the DUT against the model, then advance the model over the coming edge.
  initial begin
    logic [31:0] exp_pat;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int i = 0; i < 8; i++) exp_pat[i*4 +: 4] = m_pat[i];
        check("play_smpl", {28'b0, play}, {28'b0, e_play});
        check("beat_pulse", {31'b0, beat}, {31'b0, e_beat});
        check("step_idx", {29'b0, idx}, {29'b0, e_idx});
        check("step_onehot", {24'b0, oh}, {24'b0, e_oh});
        check("pattern", pat, exp_pat);
      end
      model_step();
      m_valid = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = MODE_PLAY; wr_en = 1'b0; wr_step = 3'd0; wr_mask = 4'b0;
    raw_mask = 4'b0; step_len = 20'd9; gate_len = 20'd6;
    step(2);
    check("rst_play", {28'b0, play}, 32'h0);
    check("rst_idx", {29'b0, idx}, 32'h0);
    check("rst_onehot", {24'b0, oh}, 32'h0);
    check("rst_beat", {31'b0, beat}, 32'h0);
    check("rst_pattern", pat, 32'h0);
    rst_n = 1'b1;
    step(1);
    check("first_beat", {31'b0, beat}, 32'h1);
    check("first_idx", {29'b0, idx}, 32'h0);
    check("first_onehot", {24'b0, oh}, 32'h1);

    mode = MODE_EDIT; wr_en = 1'b1; wr_step = 3'd0; wr_mask = 4'b1000;
    step(1);
    wr_step = 3'd1; wr_mask = 4'b0001;
    step(1);
    wr_en = 1'b0; mode = MODE_PLAY;
    step(1);
    check("entry_beat", {31'b0, beat}, 32'h1);
    for (int k = 1; k <= 161; k++) begin
      if (k == 83) begin wr_en = 1'b1; wr_step = 3'd0; wr_mask = 4'b0110; end
      step(1);
      wr_en = 1'b0;
      if (k <= 6) check("gate_on", {28'b0, play}, 32'h8);
      else if (k <= 10) check("gate_off", {28'b0, play}, 32'h0);
      else if (k == 11) check("step1_mask", {28'b0, play}, 32'h1);
      if (k == 10) check("beat_10", {31'b0, beat}, 32'h1);
      if (k == 20) check("idx_20", {29'b0, idx}, 32'h2);
      if (k == 79) begin
        check("idx_79", {29'b0, idx}, 32'h7);
        check("onehot_79", {24'b0, oh}, 32'h80);
        check("beat_79", {31'b0, beat}, 32'h0);
      end
      if (k == 80) begin
        check("wrap_idx", {29'b0, idx}, 32'h0);
        check("wrap_beat", {31'b0, beat}, 32'h1);
        check("wrap_onehot", {24'b0, oh}, 32'h1);
      end
      if (k == 84) check("edit_pattern", {28'b0, pat[3:0]}, 32'he);
      if (k == 86) check("edit_no_effect", {28'b0, play}, 32'h8);
      if (k == 161) check("edit_next_pass", {28'b0, play}, 32'he);
    end

    mode = MODE_RAW; raw_mask = 4'b0010;
    step(1);
    check("raw_play", {28'b0, play}, 32'h2);
    check("raw_idx", {29'b0, idx}, 32'h0);
    check("raw_onehot", {24'b0, oh}, 32'h0);
    mode = MODE_EDIT;
    step(1);
    check("edit_play", {28'b0, play}, 32'h0);
    mode = MODE_RSVD;
    step(1);
    check("rsvd_play", {28'b0, play}, 32'h0);
    raw_mask = 4'b0;

    wr_en = 1'b1; wr_step = 3'd0; wr_mask = 4'b0110;
    step(1);
    wr_step = 3'd1; wr_mask = 4'b1001;
    step(1);
    wr_en = 1'b0; gate_len = 20'd20; mode = MODE_PLAY;
    step(1);
    check("retrig_pattern", {24'b0, pat[7:0]}, 32'h88);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k <= 10) check("cont_gate", {28'b0, play}, 32'h8);
`ifdef STEP_SCHED_RETRIG_EN
      else if (k == 11) check("retrig_low", {28'b0, play}, 32'h0);
`else
      else if (k == 11) check("hold_high", {28'b0, play}, 32'h8);
`endif
      else check("after_retrig", {28'b0, play}, 32'h8);
    end

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 9))
          7:       mode = MODE_EDIT;
          8:       mode = MODE_RAW;
          9:       mode = MODE_RSVD;
          default: mode = MODE_PLAY;
        endcase
      end
      wr_en    = ($urandom_range(0, 7) == 0);
      wr_step  = 3'($urandom_range(0, 7));
      wr_mask  = 4'($urandom_range(0, 15));
      raw_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      if ($urandom_range(0, 49) == 0) step_len = 20'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) gate_len = 20'($urandom_range(0, 8));
      step(1);
    end
    rst_n = 1'b1; wr_en = 1'b0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
